instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Fetch/decode/execute control unit for the mini-CISC core. It drives the program counter into the registered-read instruction store and captures the returned byte into an instruction register. It decodes the opcode and issues one-cycle control strobes to the accumulator/ALU datapath. It also owns run/halt control and a retired-instruction counter.

## Interface
- `MEM_DEPTH`, 16: instruction store depth; PC wraps modulo this value (power of two, ≤256).
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `run` input 1: level; 1 = execute, 0 = stop at next instruction boundary.
- `instr` input 8: registered output of instruction store; valid one cycle after `pc` is presented.
- `zero` input 1: accumulator-zero flag from datapath, sampled in EXECUTE.
- `pc` output 8: instruction address to store.
- `ir` output 8: latched instruction.
- `operand` output 4: `ir[3:0]`, immediate/jump target.
- `alu_op` output 3: 0 pass, 1 add, 2 sub, 3 and, 4 or.
- `acc_we` output 1: accumulator write strobe, one cycle.
- `busy` output 1: state ≠ IDLE and ≠ HALT.
- `halted` output 1: state = HALT.
- `illegal` output 1: one-cycle pulse on undefined opcode.
- `retired` output 8: retired-instruction count, saturating.

## Operation
- Opcode is `ir[7:4]`:
  - 0x0 NOP.
  - 0x1 LDI: `alu_op`=0, `acc_we`.
  - 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR: `alu_op` 1–4, `acc_we`.
  - 0x6 JMP: pc←operand.
  - 0x7 JZ: pc←operand if `zero`, else pc+1.
  - 0xF HLT.
  - 0x8–0xE: illegal; executed as NOP with `illegal` pulse.
- States: IDLE, FETCH, DECODE, EXECUTE, HALT.
  - IDLE→FETCH when `run`=1.
  - FETCH→DECODE unconditionally. `pc` is stable during FETCH; the store captures it at the end of the cycle.
  - DECODE→EXECUTE. `ir`←`instr` at the end of DECODE.
  - EXECUTE: strobes asserted for this cycle only. At the end of the cycle, pc is updated and the instruction is retired.
  - EXECUTE→HALT on HLT.
  - EXECUTE→IDLE if `run`=0.
  - Otherwise EXECUTE→FETCH.
  - HALT is terminal until reset. `run` is ignored in HALT.
- PC arithmetic: next pc = (pc+1) mod `MEM_DEPTH`, so 15→0 at depth 16. Jump targets are zero-extended to 8 bits and are not wrapped beyond `MEM_DEPTH`-1.
- `retired` increments on every EXECUTE exit, including NOP, illegal and HLT. It saturates at 255.
- `run` deasserted mid-instruction: the current instruction completes, then the block enters IDLE with pc pointing at the next instruction. Reasserting `run` resumes from that pc.

## Timing
- Reset values: state IDLE, `pc`=0, `ir`=0, `alu_op`=0, `acc_we`=0, `illegal`=0, `retired`=0, `busy`=0, `halted`=0.
- Every instruction takes 3 cycles: FETCH, DECODE, EXECUTE.
- The first FETCH is the cycle after `run` is sampled high in IDLE.
- `acc_we`, `alu_op`≠0 and `illegal` are asserted only in EXECUTE. `alu_op` is 0 in every other state.
- `zero` is sampled at the EXECUTE clock edge only.
- Reset asserted in any state forces reset values immediately, with no completion of the in-flight instruction.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (OP_NOP…OP_HLT);
  - `alu_op` encodings;
  - state encoding.
  The datapath and ALU use the same constants.
- Sub-module `instr_decoder`: purely combinational, maps `ir` to `alu_op`, `acc_we`, is_jmp, is_jz, is_hlt, is_illegal.
- The sequencer instantiates `instr_decoder` and gates its outputs with EXECUTE.

## Test plan
- Program 0x16, 0x2B, 0x31, 0x4B, 0x51, 0x1B, 0x21, 0xF0 with `run`=1. Required:
  - `acc_we` pulses in cycles 3, 6, …, 21, with `alu_op` sequence 0,1,2,3,4,0,1;
  - HALT after 24 cycles;
  - `retired`=8, `pc`=8.
- 0x63 at address 0. Required: pc 0→3, `acc_we` never asserted.
- 0x75 with `zero`=1. Required: pc→5.
- 0x75 with `zero`=0. Required: pc→1.
- 16 NOPs at `MEM_DEPTH`=16. Required: pc wraps 15→0 and `retired` reaches 16. Continuing runs `retired` to 255 and it holds there.
- `run` dropped during DECODE of the instruction at pc=2. Required: EXECUTE completes, then IDLE with pc=3; reassert `run` and the next FETCH presents 3.
- `rst` pulled low during EXECUTE of 0x2B. Required: all outputs return to reset values at once, with no `retired` increment.
- Opcode 0x9A. Required: a single-cycle `illegal` pulse and pc+1.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Constants shared by the mini-CISC control and datapath:
//               opcodes, ALU operation encodings, sequencer state encoding
//               and the saturating retire-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Opcodes live in ir[7:4]; 0x8..0xE are undefined.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation select driven to the accumulator datapath.
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  // Sequencer state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FETCH   = 3'd1;
  localparam state_t ST_DECODE  = 3'd2;
  localparam state_t ST_EXECUTE = 3'd3;
  localparam state_t ST_HALT    = 3'd4;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Purely combinational opcode decoder. Maps the opcode field
//               of the instruction register onto datapath controls and
//               instruction-class flags. Outputs are not qualified by state;
//               the sequencer gates them with EXECUTE.
// Ports       : opcode_i     - ir[7:4]
//               alu_op_o     - ALU operation select
//               acc_we_o     - accumulator write request
//               is_jmp_o     - unconditional jump
//               is_jz_o      - jump if accumulator zero
//               is_hlt_o     - halt
//               is_illegal_o - undefined opcode (0x8..0xE)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic [2:0] alu_op_o,
  output logic       acc_we_o,
  output logic       is_jmp_o,
  output logic       is_jz_o,
  output logic       is_hlt_o,
  output logic       is_illegal_o
);

  always_comb begin
    alu_op_o     = ALU_PASS;
    acc_we_o     = 1'b0;
    is_jmp_o     = 1'b0;
    is_jz_o      = 1'b0;
    is_hlt_o     = 1'b0;
    is_illegal_o = 1'b0;
    case (opcode_i)
      OP_NOP: ;
      OP_LDI: acc_we_o = 1'b1;
      OP_ADD: begin alu_op_o = ALU_ADD; acc_we_o = 1'b1; end
      OP_SUB: begin alu_op_o = ALU_SUB; acc_we_o = 1'b1; end
      OP_AND: begin alu_op_o = ALU_AND; acc_we_o = 1'b1; end
      OP_OR:  begin alu_op_o = ALU_OR;  acc_we_o = 1'b1; end
      OP_JMP: is_jmp_o = 1'b1;
      OP_JZ:  is_jz_o  = 1'b1;
      OP_HLT: is_hlt_o = 1'b1;
      default: is_illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/decode/execute control unit. Presents the PC to a
//               registered-read instruction store, latches the returned byte
//               into IR, and issues one-cycle control strobes in EXECUTE.
//               Owns run/halt control and a saturating retired counter.
// Ports       : clk_i       - clock, rising edge
//               rst_ni      - asynchronous active-low reset
//               run_i       - 1 = execute, 0 = stop at instruction boundary
//               instr_i     - instruction store read data (1-cycle latency)
//               zero_i      - accumulator-zero flag, used by JZ in EXECUTE
//               pc_o        - instruction address
//               ir_o        - latched instruction
//               operand_o   - ir[3:0], immediate / jump target
//               alu_op_o    - ALU operation (0 outside EXECUTE)
//               acc_we_o    - accumulator write strobe
//               busy_o      - in FETCH, DECODE or EXECUTE
//               halted_o    - in HALT
//               illegal_o   - undefined opcode pulse
//               retired_o   - retired instruction count, saturating at 255
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic [7:0] instr_i,
  input  logic       zero_i,
  output logic [7:0] pc_o,
  output logic [7:0] ir_o,
  output logic [3:0] operand_o,
  output logic [2:0] alu_op_o,
  output logic       acc_we_o,
  output logic       busy_o,
  output logic       halted_o,
  output logic       illegal_o,
  output logic [7:0] retired_o
);

  // MEM_DEPTH is a power of two, so the wrap is a simple mask.
  localparam logic [7:0] PC_MASK = 8'(MEM_DEPTH - 1);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] retired_q, retired_d;

  logic [2:0] dec_alu_op;
  logic       dec_acc_we;
  logic       dec_is_jmp;
  logic       dec_is_jz;
  logic       dec_is_hlt;
  logic       dec_is_illegal;
  logic       in_exec;

  instr_decoder u_decoder (
    .opcode_i     (ir_q[7:4]),
    .alu_op_o     (dec_alu_op),
    .acc_we_o     (dec_acc_we),
    .is_jmp_o     (dec_is_jmp),
    .is_jz_o      (dec_is_jz),
    .is_hlt_o     (dec_is_hlt),
    .is_illegal_o (dec_is_illegal)
  );

  assign in_exec = (state_q == ST_EXECUTE);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. HALT has priority over a dropped run so a halting
  // instruction always ends in HALT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (run_i) state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_DECODE;
      ST_DECODE:  state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (dec_is_hlt)  state_d = ST_HALT;
        else if (!run_i) state_d = ST_IDLE;
        else             state_d = ST_FETCH;
      end
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: decoder controls only reach the datapath in EXECUTE.
  always_comb begin
    alu_op_o  = in_exec ? dec_alu_op : ALU_PASS;
    acc_we_o  = in_exec & dec_acc_we;
    illegal_o = in_exec & dec_is_illegal;
    busy_o    = (state_q != ST_IDLE) && (state_q != ST_HALT);
    halted_o  = (state_q == ST_HALT);
  end

  // PC / IR / retire counter next values.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    // Store data for the PC presented in FETCH is valid during DECODE.
    if (state_q == ST_DECODE) begin
      ir_d = instr_i;
    end
    if (in_exec) begin
      retired_d = sat_inc8(retired_q);
      // Jump targets are taken as-is (zero-extended), not masked.
      if (dec_is_jmp || (dec_is_jz && zero_i)) begin
        pc_d = {4'h0, ir_q[3:0]};
      end else begin
        pc_d = (pc_q + 8'd1) & PC_MASK;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= 8'd0;
      ir_q      <= 8'd0;
      retired_q <= 8'd0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  assign pc_o      = pc_q;
  assign ir_o      = ir_q;
  assign operand_o = ir_q[3:0];
  assign retired_o = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer. An instruction-level
//               reference model (3 cycles per instruction, semantics taken
//               straight from the opcode table) predicts every output each
//               cycle; directed programs and randomized programs drive it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic       zero = 1'b0;
  logic [7:0] instr = 8'h00;
  logic [7:0] pc, ir, retired;
  logic [3:0] operand;
  logic [2:0] alu_op;
  logic       acc_we, busy, halted, illegal;

  logic [7:0] mem [16];

  always #5 clk = ~clk;

  // Registered-read instruction store.
  always @(posedge clk) instr <= mem[pc[3:0]];

  instr_sequencer #(.MEM_DEPTH(16)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .run_i     (run),
    .instr_i   (instr),
    .zero_i    (zero),
    .pc_o      (pc),
    .ir_o      (ir),
    .operand_o (operand),
    .alu_op_o  (alu_op),
    .acc_we_o  (acc_we),
    .busy_o    (busy),
    .halted_o  (halted),
    .illegal_o (illegal),
    .retired_o (retired)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode;   // 0 idle, 1 running, 2 halted
  int m_slot;   // cycle within current instruction: 0,1,2 (2 = execute)
  int m_pc;
  int m_ret;
  int cyc;
  int we_cyc[$];
  int we_op[$];
  int ill_cnt;
  int halt_cyc;

  task automatic model_reset();
    m_mode = 0; m_slot = 0; m_pc = 0; m_ret = 0; cyc = 0;
    we_cyc.delete(); we_op.delete(); ill_cnt = 0; halt_cyc = -1;
  endtask

  task automatic exp_ctl(input logic [7:0] b, output logic [2:0] op,
                         output logic we, output logic ill);
    int o;
    o = int'(b[7:4]);
    op = 3'd0; we = 1'b0; ill = 1'b0;
    if (o == 1) we = 1'b1;
    else if (o >= 2 && o <= 5) begin op = 3'(o - 1); we = 1'b1; end
    else if (o >= 8 && o <= 14) ill = 1'b1;
  endtask

  task automatic model_edge();
    logic [7:0] b;
    b = mem[m_pc % 16];
    if (m_mode == 0) begin
      if (run) begin m_mode = 1; m_slot = 0; end
    end else if (m_mode == 1) begin
      if (m_slot < 2) m_slot++;
      else begin
        if (b[7:4] == 4'h6 || (b[7:4] == 4'h7 && zero)) m_pc = int'(b[3:0]);
        else m_pc = (m_pc + 1) % 16;
        if (m_ret < 255) m_ret++;
        if (b[7:4] == 4'hF) m_mode = 2;
        else if (!run) m_mode = 0;
        else m_slot = 0;
      end
    end
  endtask

  task automatic check_now();
    logic [7:0] b;
    logic [2:0] eop;
    logic ewe, eill, ex;
    ex = (m_mode == 1 && m_slot == 2);
    b = mem[m_pc % 16];
    eop = 3'd0; ewe = 1'b0; eill = 1'b0;
    if (ex) exp_ctl(b, eop, ewe, eill);
    chk("pc", pc, m_pc);
    chk("busy", busy, m_mode == 1);
    chk("halted", halted, m_mode == 2);
    chk("retired", retired, m_ret);
    chk("alu_op", alu_op, eop);
    chk("acc_we", acc_we, ewe);
    chk("illegal", illegal, eill);
    if (ex) begin
      chk("ir", ir, b);
      chk("operand", operand, b[3:0]);
    end
    if (acc_we) begin we_cyc.push_back(cyc); we_op.push_back(int'(alu_op)); end
    if (illegal) ill_cnt++;
    if (halted && halt_cyc < 0) halt_cyc = cyc;
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      check_now();
    end
  endtask

  // Reset asserted for one cycle, released at a falling edge; the half cycle
  // after release is cycle 0.
  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now();
    chk("rst_ir", ir, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  initial begin
    int exp_c[7];
    int exp_o[7];
    logic [7:0] prog[8];
    int found;
    exp_c = '{3, 6, 9, 12, 15, 18, 21};
    exp_o = '{0, 1, 2, 3, 4, 0, 1};
    prog  = '{8'h16, 8'h2B, 8'h31, 8'h4B, 8'h51, 8'h1B, 8'h21, 8'hF0};

    // Program 1: ALU sequence then halt.
    fill(8'h00);
    for (int i = 0; i < 8; i++) mem[i] = prog[i];
    run = 1'b1; zero = 1'b0;
    reset_dut();
    step(25);
    chk("p1_we_count", we_cyc.size(), 7);
    for (int i = 0; i < 7 && i < we_cyc.size(); i++) begin
      chk("p1_we_cycle", we_cyc[i], exp_c[i]);
      chk("p1_alu_op", we_op[i], exp_o[i]);
    end
    chk("p1_halt_cycle", halt_cyc, 25);
    chk("p1_retired", retired, 8);
    chk("p1_pc", pc, 8);
    run = 1'b0;
    step(3);
    chk("p1_halt_sticky", halted, 1);

    // JMP 3.
    fill(8'h00); mem[0] = 8'h63; mem[4] = 8'hF0;
    run = 1'b1;
    reset_dut();
    step(4);
    chk("jmp_pc", pc, 3);
    step(8);
    chk("jmp_no_we", we_cyc.size(), 0);

    // JZ 5 taken / not taken.
    fill(8'hF0); mem[0] = 8'h75;
    zero = 1'b1;
    reset_dut();
    step(4);
    chk("jz_taken_pc", pc, 5);
    zero = 1'b0;
    reset_dut();
    step(4);
    chk("jz_fall_pc", pc, 1);

    // NOP wrap and retire saturation.
    fill(8'h00);
    reset_dut();
    step(49);
    chk("wrap_retired16", retired, 16);
    chk("wrap_pc0", pc, 0);
    step(800);
    chk("sat_retired", retired, 255);
    step(9);
    chk("sat_hold", retired, 255);

    // run dropped during DECODE at pc=2.
    reset_dut();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (m_mode == 1 && m_slot == 1 && m_pc == 2) found = 1;
    end
    chk("stop_reached_decode", found, 1);
    run = 1'b0;
    step();
    chk("stop_exec_busy", busy, 1);
    step();
    chk("stop_idle", busy, 0);
    chk("stop_pc", pc, 3);
    step(4);
    run = 1'b1;
    step();
    chk("resume_busy", busy, 1);
    chk("resume_pc", pc, 3);
    step(6);

    // Reset during EXECUTE of 0x2B.
    fill(8'h00); mem[0] = 8'h2B;
    reset_dut();
    step(3);
    chk("rst_exec_we", acc_we, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_ir", ir, 0);
    chk("arst_alu", alu_op, 0);
    chk("arst_we", acc_we, 0);
    chk("arst_ill", illegal, 0);
    chk("arst_ret", retired, 0);
    chk("arst_busy", busy, 0);
    chk("arst_halted", halted, 0);
    reset_dut();
    step(6);

    // Illegal opcode.
    fill(8'h00); mem[0] = 8'h9A;
    reset_dut();
    step(5);
    chk("ill_pulses", ill_cnt, 1);
    chk("ill_pc", pc, 1);

    // Randomized programs with random zero flag and run drops.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] = 8'($urandom);
        if (mem[i][7:4] == 4'hF && ($urandom % 4) != 0) mem[i][7:4] = 4'h0;
      end
      run = 1'b1;
      reset_dut();
      for (int c = 0; c < 150; c++) begin
        zero = 1'($urandom % 2);
        run  = (($urandom % 8) != 0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
